// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: bundle between the ID-stage decoder and the hazard/forwarding controller.
// Latency: none, plain wires; the controller registers the select codes itself.
// Backpressure: stall flows back to the decoder, which must keep presenting the same instruction.
interface hazard_fwd_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic                  id_flush;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_imm;
    logic                  id_regwrite;
    logic [REG_ADDR_W-1:0] id_dst;
    logic [1:0]            id_wbsel;
    logic                  stall;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            alusrc_sel;
    logic [CNT_W-1:0]      stall_cnt;

    // Decoder side: presents the ID instruction, receives stall and selects.
    modport master (
        output id_valid, id_flush, id_rs, id_rt, id_use_rs, id_use_rt,
               id_imm, id_regwrite, id_dst, id_wbsel,
        input  stall, fwd_a_sel, alusrc_sel, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_flush, id_rs, id_rt, id_use_rs, id_use_rt,
               id_imm, id_regwrite, id_dst, id_wbsel,
        output stall, fwd_a_sel, alusrc_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: tracks EX/MEM producers, drives EX operand-select codes and the ID stall; HAZARD_FWD_EN enables forwarding.
// Latency: stall is combinational in ID; select codes are registered and valid during the consumer's EX cycle.
// Backpressure: stall holds PC and IF/ID only; the EX/MEM tracking shifts every cycle and never freezes.
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_fwd_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [1:0]            SEL_REG   = 2'b00;
    localparam logic [1:0]            SEL_IMM   = 2'b01;
`ifdef HAZARD_FWD_EN
    localparam logic [1:0]            SEL_EX    = 2'b10;
    localparam logic [1:0]            SEL_WB    = 2'b11;
    localparam logic [1:0]            WB_DM     = 2'b01;
`endif

    // A stage record only needs "will write a register" (valid & regwrite folded)
    // and the destination. The WB stage is not tracked: the register file is
    // write-before-read, so a producer in WB is already visible to ID.
    typedef struct packed {
        logic                  wr;
        logic [REG_ADDR_W-1:0] dst;
    } rec_t;

    rec_t             ex_rec;
    rec_t             mem_rec;
    rec_t             ex_nxt;
    logic             rs_live;
    logic             rt_live;
    logic             rs_ex;
    logic             rt_ex;
    logic             rs_mem;
    logic             rt_mem;
    logic             issue;
    logic             accept;
    logic             stall_i;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_a_nxt;
    logic [1:0]       alusrc_q;
    logic [1:0]       alusrc_nxt;
    logic [CNT_W-1:0] stall_cnt_q;
`ifdef HAZARD_FWD_EN
    logic             ex_load;
    logic             ex_load_nxt;
`endif

    // Source-versus-producer matches; ZERO_REG is hard-wired and never a hazard.
    always_comb begin
        rs_live = bus.id_use_rs && (bus.id_rs != ZERO_ADDR);
        rt_live = bus.id_use_rt && (bus.id_rt != ZERO_ADDR);
        rs_ex   = rs_live && ex_rec.wr  && (ex_rec.dst  == bus.id_rs);
        rt_ex   = rt_live && ex_rec.wr  && (ex_rec.dst  == bus.id_rt);
        rs_mem  = rs_live && mem_rec.wr && (mem_rec.dst == bus.id_rs);
        rt_mem  = rt_live && mem_rec.wr && (mem_rec.dst == bus.id_rt);
    end

    // Flush always beats a hazard: a squashed instruction never stalls.
    assign issue = bus.id_valid && !bus.id_flush;

`ifdef HAZARD_FWD_EN
    // Only a load sitting in EX cannot be forwarded in time.
    assign stall_i = issue && ex_load && (rs_ex || rt_ex);
`else
    // Without forwarding the consumer waits until its producer reaches WB.
    assign stall_i = issue && (rs_ex || rt_ex || rs_mem || rt_mem);
`endif

    assign accept = issue && !stall_i;

    // Record entering EX and the select codes it will need there; bubbles get 00.
    always_comb begin
        ex_nxt     = '0;
        fwd_a_nxt  = SEL_REG;
        alusrc_nxt = SEL_REG;
`ifdef HAZARD_FWD_EN
        ex_load_nxt = 1'b0;
`endif
        if (accept) begin
            ex_nxt.wr  = bus.id_regwrite;
            ex_nxt.dst = bus.id_dst;
`ifdef HAZARD_FWD_EN
            ex_load_nxt = (bus.id_wbsel == WB_DM);
            // The youngest producer wins: EX before MEM.
            if (rs_ex) begin
                fwd_a_nxt = SEL_EX;
            end else if (rs_mem) begin
                fwd_a_nxt = SEL_WB;
            end
            // An immediate operand replaces rt entirely, so no forward on it.
            if (bus.id_imm) begin
                alusrc_nxt = SEL_IMM;
            end else if (rt_ex) begin
                alusrc_nxt = SEL_EX;
            end else if (rt_mem) begin
                alusrc_nxt = SEL_WB;
            end
`else
            if (bus.id_imm) begin
                alusrc_nxt = SEL_IMM;
            end
`endif
        end
    end

    // Pipeline shift, registered selects and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rec      <= '0;
            mem_rec     <= '0;
            fwd_a_q     <= SEL_REG;
            alusrc_q    <= SEL_REG;
            stall_cnt_q <= '0;
`ifdef HAZARD_FWD_EN
            ex_load     <= 1'b0;
`endif
        end else begin
            ex_rec   <= ex_nxt;
            mem_rec  <= ex_rec;
            fwd_a_q  <= fwd_a_nxt;
            alusrc_q <= alusrc_nxt;
            if (stall_i && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
`ifdef HAZARD_FWD_EN
            ex_load  <= ex_load_nxt;
`endif
        end
    end

    assign bus.stall      = stall_i;
    assign bus.fwd_a_sel  = fwd_a_q;
    assign bus.alusrc_sel = alusrc_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench for hazard_fwd_ctrl in either HAZARD_FWD_EN build.
// Reference model keeps, per architectural register, the cycle its youngest producer entered EX.
// A narrow stall counter is used so saturation is reachable.
module tb_hazard_fwd_ctrl;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic          valid;
        logic          flush;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
        logic          imm;
        logic          regwrite;
        logic [AW-1:0] dst;
        logic [1:0]    wbsel;
    } ins_t;

    typedef struct packed {
        logic          stall;
        logic [1:0]    a;
        logic [1:0]    b;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    hazard_fwd_ctrl #(.REG_ADDR_W(AW), .ZERO_REG(0), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state.
    int         cyc = 0;
    int         wr_cyc[NREG];
    bit         wr_load[NREG];
    logic [1:0] m_a = 2'b00;
    logic [1:0] m_b = 2'b00;
    int         m_cnt = 0;

    function automatic ins_t nop();
        ins_t i;
        i = '0;
        return i;
    endfunction

    function automatic ins_t alu(int d, int s, int t);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = AW'(s); i.rt = AW'(t);
        i.use_rs = 1'b1; i.use_rt = 1'b1; i.regwrite = 1'b1;
        i.dst = AW'(d); i.wbsel = 2'b00;
        return i;
    endfunction

    function automatic ins_t addi(int d, int s);
        ins_t i;
        i = alu(d, s, 0);
        i.use_rt = 1'b0; i.imm = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(int d, int s);
        ins_t i;
        i = addi(d, s);
        i.wbsel = 2'b01;
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i.valid    = ($urandom_range(0, 9) != 0);
        i.flush    = ($urandom_range(0, 11) == 0);
        i.rs       = AW'($urandom_range(0, 3));
        i.rt       = AW'($urandom_range(0, 3));
        i.use_rs   = ($urandom_range(0, 4) != 0);
        i.use_rt   = ($urandom_range(0, 2) != 0);
        i.imm      = ($urandom_range(0, 2) == 0);
        i.regwrite = ($urandom_range(0, 3) != 0);
        i.dst      = AW'($urandom_range(0, 3));
        i.wbsel    = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
        return i;
    endfunction

    // Cycles since the youngest producer of r entered EX (0 = in EX, 1 = in MEM).
    function automatic int age(logic [AW-1:0] r, logic used);
        if (!used || r == '0) return 99;
        return cyc - wr_cyc[r];
    endfunction

    // Present one instruction for one cycle, push the expected outputs, advance the model.
    task automatic cycle(input logic r, input ins_t i, output logic st);
        int   da;
        int   db;
        logic iss;
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.id_valid    = i.valid;
        bus.id_flush    = i.flush;
        bus.id_rs       = i.rs;
        bus.id_rt       = i.rt;
        bus.id_use_rs   = i.use_rs;
        bus.id_use_rt   = i.use_rt;
        bus.id_imm      = i.imm;
        bus.id_regwrite = i.regwrite;
        bus.id_dst      = i.dst;
        bus.id_wbsel    = i.wbsel;
        da  = age(i.rs, i.use_rs);
        db  = age(i.rt, i.use_rt);
        iss = i.valid && !i.flush;
`ifdef HAZARD_FWD_EN
        st = iss && ((da == 0 && wr_load[i.rs]) || (db == 0 && wr_load[i.rt]));
`else
        st = iss && (da <= 1 || db <= 1);
`endif
        e.stall = st;
        e.a     = m_a;
        e.b     = m_b;
        e.cnt   = CW'(m_cnt);
        sb.push_back(e);
        if (r) begin
            for (int k = 0; k < NREG; k++) begin
                wr_cyc[k]  = -1000;
                wr_load[k] = 1'b0;
            end
            m_a   = 2'b00;
            m_b   = 2'b00;
            m_cnt = 0;
        end else begin
            m_a = 2'b00;
            m_b = 2'b00;
            if (iss && !st) begin
`ifdef HAZARD_FWD_EN
                m_a = (da == 0) ? 2'b10 : (da == 1) ? 2'b11 : 2'b00;
                m_b = i.imm ? 2'b01 : (db == 0) ? 2'b10 : (db == 1) ? 2'b11 : 2'b00;
`else
                m_b = i.imm ? 2'b01 : 2'b00;
`endif
                if (i.regwrite) begin
                    wr_cyc[i.dst]  = cyc + 1;
                    wr_load[i.dst] = (i.wbsel == 2'b01);
                end
            end
            if (st && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        cyc++;
    endtask

    // Decoder behaviour: keep re-presenting the instruction while it is stalled.
    task automatic issue(input ins_t i);
        logic st;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, i, st);
            if (!st) break;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",      32'(bus.stall),      32'(e.stall));
            chk("fwd_a_sel",  32'(bus.fwd_a_sel),  32'(e.a));
            chk("alusrc_sel", 32'(bus.alusrc_sel), 32'(e.b));
            chk("stall_cnt",  32'(bus.stall_cnt),  32'(e.cnt));
        end
    end

    initial begin
        ins_t cur;
        ins_t fl;
        logic st;
        for (int k = 0; k < NREG; k++) begin
            wr_cyc[k]  = -1000;
            wr_load[k] = 1'b0;
        end
        cur = nop();
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_flush = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_imm = 1'b0;
        bus.id_regwrite = 1'b0; bus.id_dst = '0; bus.id_wbsel = 2'b00;
        @(posedge clk);
        cycle(1'b1, nop(), st);
        cycle(1'b1, nop(), st);

        // Back-to-back ALU dependence.
        issue(alu(3, 1, 2)); issue(alu(4, 3, 5)); issue(nop()); issue(nop());
        // Dependence across one bubble, on rt.
        issue(alu(3, 1, 2)); issue(nop()); issue(alu(6, 1, 3)); issue(nop()); issue(nop());
        // Load-use on both operands.
        issue(lw(3, 1)); issue(alu(4, 3, 3)); issue(nop()); issue(nop());
        // Register zero, then immediate consumer.
        issue(alu(0, 1, 2)); issue(alu(5, 0, 0));
        issue(alu(3, 1, 2)); issue(addi(4, 3)); issue(nop()); issue(nop());
        // Flush against a load-use hazard.
        issue(lw(3, 1));
        fl = alu(4, 3, 3); fl.flush = 1'b1;
        cycle(1'b0, fl, st);
        issue(nop()); issue(nop());
        // Reset in the middle of a stall.
        issue(lw(3, 1));
        cycle(1'b0, alu(4, 3, 5), st);
        cycle(1'b1, alu(4, 3, 5), st);
        issue(alu(4, 3, 5)); issue(nop()); issue(nop());
        // Drive the stall counter into saturation.
        for (int n = 0; n < 20; n++) begin
            issue(lw(3, 1)); issue(alu(4, 3, 3));
        end
        issue(nop()); issue(nop());

        // Randomized traffic with occasional reset; stalled instructions usually held.
        st = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!st || $urandom_range(0, 3) == 0) cur = rnd();
            cycle($urandom_range(0, 199) == 0, cur, st);
        end
        issue(nop()); issue(nop());

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
